memshare_alloc_seq_issuer: RTL

Consumer end of the arrival-requestor profiling path in SCU.memShare(). The profiler pushes one tracked request pattern per cycle, each tagged with its design-rule-check (DRC) class and allocation-sequence count. This block buffers up to ARR_RQST_TRACK_DEPTH entries and replays each one downstream as 1..MAX_ALLOC_SEQ_NUM allocation-sequence beats over a valid/ready handshake.

---
 rtl/memshare_alloc_seq_issuer.sv | 197 +++++++++++++++++++
 1 files changed

// File: rtl/memshare_alloc_seq_issuer.sv
// memshare_alloc_seq_issuer
// Buffers tracked request patterns from the arrival-requestor profiler and
// replays each one downstream as 1..MAX_SEQ allocation-sequence beats over a
// valid/ready handshake. Illegal and overflowing pushes are dropped and
// recorded in sticky error flags.
module memshare_alloc_seq_issuer #(
  parameter int RQST_NUM    = 5,
  parameter int TRACK_DEPTH = 4,
  parameter int MAX_SEQ     = 2,
  parameter int DRC_NUM     = 3
) (
  input  logic                sys_clk,
  input  logic                rst,
  input  logic                prof_wr_en,
  input  logic [RQST_NUM-1:0] prof_rqst_pattern,
  input  logic [1:0]          prof_drc,
  input  logic [1:0]          prof_seq_num,
  output logic                prof_full,
  output logic                alloc_valid,
  input  logic                alloc_ready,
  output logic [RQST_NUM-1:0] alloc_pattern,
  output logic [1:0]          alloc_drc,
  output logic                alloc_seq_id,
  output logic                alloc_last,
  output logic [2:0]          track_cnt,
  output logic                ovf_err,
  output logic                drc_err
);

  localparam int         PTR_W   = (TRACK_DEPTH > 1) ? $clog2(TRACK_DEPTH) : 1;
  localparam logic [2:0] DEPTH_C = 3'(TRACK_DEPTH);
  localparam logic [2:0] DRC_LIM = 3'(DRC_NUM);
  localparam logic [2:0] SEQ_LIM = 3'(MAX_SEQ);

  typedef enum logic {
    IDLE  = 1'b0,
    ISSUE = 1'b1
  } state_t;

  // Circular pointer advance that also works for non-power-of-two depths.
  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(TRACK_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  state_t              state_q, state_d;

  logic [RQST_NUM-1:0] pat_mem_q [TRACK_DEPTH];
  logic [RQST_NUM-1:0] pat_mem_d [TRACK_DEPTH];
  logic [1:0]          drc_mem_q [TRACK_DEPTH];
  logic [1:0]          drc_mem_d [TRACK_DEPTH];
  logic [1:0]          seq_mem_q [TRACK_DEPTH];
  logic [1:0]          seq_mem_d [TRACK_DEPTH];

  logic [PTR_W-1:0]    rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d;
  logic [2:0]          cnt_q, cnt_d;

  // Output stage: the entry currently being replayed.
  logic [RQST_NUM-1:0] out_pat_q, out_pat_d;
  logic [1:0]          out_drc_q, out_drc_d;
  logic [1:0]          out_seq_num_q, out_seq_num_d;
  logic                seq_cnt_q, seq_cnt_d;

  logic                ovf_err_q, ovf_err_d;
  logic                drc_err_q, drc_err_d;

  logic                entry_legal;
  logic                buf_full;
  logic                push;
  logic                pop;
  logic                beat_last;

  // Push qualification: legality is judged before fullness so an illegal
  // push at full is reported only as a DRC error.
  always_comb begin
    entry_legal = ({1'b0, prof_drc} < DRC_LIM) &&
                  (prof_seq_num != 2'd0) &&
                  ({1'b0, prof_seq_num} <= SEQ_LIM);
    buf_full    = (cnt_q == DEPTH_C);
    push        = prof_wr_en && entry_legal && !buf_full;
    beat_last   = ({1'b0, seq_cnt_q} == (out_seq_num_q - 2'd1));
  end

  // FSM next state and output-stage load; the next entry is popped on the
  // same edge as the last beat's handshake so entries issue without bubbles.
  always_comb begin
    state_d       = state_q;
    pop           = 1'b0;
    out_pat_d     = out_pat_q;
    out_drc_d     = out_drc_q;
    out_seq_num_d = out_seq_num_q;
    seq_cnt_d     = seq_cnt_q;

    case (state_q)
      IDLE: begin
        if (cnt_q != 3'd0) begin
          pop     = 1'b1;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        if (alloc_ready) begin
          if (!beat_last) begin
            seq_cnt_d = seq_cnt_q + 1'b1;
          end else if (cnt_q != 3'd0) begin
            pop = 1'b1;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    if (pop) begin
      out_pat_d     = pat_mem_q[rd_ptr_q];
      out_drc_d     = drc_mem_q[rd_ptr_q];
      out_seq_num_d = seq_mem_q[rd_ptr_q];
      seq_cnt_d     = 1'b0;
    end
  end

  // Circular buffer write, pointer advance and occupancy count.
  always_comb begin
    pat_mem_d = pat_mem_q;
    drc_mem_d = drc_mem_q;
    seq_mem_d = seq_mem_q;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    cnt_d     = cnt_q + {2'b00, push} - {2'b00, pop};

    if (push) begin
      pat_mem_d[wr_ptr_q] = prof_rqst_pattern;
      drc_mem_d[wr_ptr_q] = prof_drc;
      seq_mem_d[wr_ptr_q] = prof_seq_num;
      wr_ptr_d            = next_ptr(wr_ptr_q);
    end
    if (pop) begin
      rd_ptr_d = next_ptr(rd_ptr_q);
    end
  end

  // Sticky error flags, cleared only by reset.
  always_comb begin
    ovf_err_d = ovf_err_q | (prof_wr_en & entry_legal & buf_full);
    drc_err_d = drc_err_q | (prof_wr_en & ~entry_legal);
  end

  // State registers; reset flushes the buffer and zeroes every output.
  always_ff @(posedge sys_clk or posedge rst) begin
    if (rst) begin
      state_q       <= IDLE;
      rd_ptr_q      <= '0;
      wr_ptr_q      <= '0;
      cnt_q         <= '0;
      out_pat_q     <= '0;
      out_drc_q     <= '0;
      out_seq_num_q <= '0;
      seq_cnt_q     <= 1'b0;
      ovf_err_q     <= 1'b0;
      drc_err_q     <= 1'b0;
      for (int i = 0; i < TRACK_DEPTH; i++) begin
        pat_mem_q[i] <= '0;
        drc_mem_q[i] <= '0;
        seq_mem_q[i] <= '0;
      end
    end else begin
      state_q       <= state_d;
      rd_ptr_q      <= rd_ptr_d;
      wr_ptr_q      <= wr_ptr_d;
      cnt_q         <= cnt_d;
      out_pat_q     <= out_pat_d;
      out_drc_q     <= out_drc_d;
      out_seq_num_q <= out_seq_num_d;
      seq_cnt_q     <= seq_cnt_d;
      ovf_err_q     <= ovf_err_d;
      drc_err_q     <= drc_err_d;
      pat_mem_q     <= pat_mem_d;
      drc_mem_q     <= drc_mem_d;
      seq_mem_q     <= seq_mem_d;
    end
  end

  // Output mapping.
  always_comb begin
    alloc_valid   = (state_q == ISSUE);
    alloc_pattern = out_pat_q;
    alloc_drc     = out_drc_q;
    alloc_seq_id  = seq_cnt_q;
    alloc_last    = (state_q == ISSUE) && beat_last;
    prof_full     = buf_full;
    track_cnt     = cnt_q;
    ovf_err       = ovf_err_q;
    drc_err       = drc_err_q;
  end

endmodule
